// File: rtl/nibble_bus_responder.sv
// nibble_bus_responder
//   Responder on the CPU nibble bus. It decodes one 256-nibble page selected by
//   BASE_PAGE and serves:
//     00-1F scratch RAM, 20 CTRL, 21 STATUS, 22/23 RELOAD, 24/25 COUNT,
//     30/31 GPIO_OUT, 32/33 GPIO_IN (synchronized).
//   Ports:
//     clk, rst_n       clock, synchronous active-low reset
//     bus_addr         12-bit CPU address ([11:8] page, [7:0] offset)
//     bus_data_rw      1 = CPU write, 0 = CPU read
//     bus_data_in      write data from CPU
//     bus_data_out     registered read data (one cycle after the address)
//     bus_data_oe      high while bus_data_out carries read data
//     gpio_in          asynchronous external inputs
//     gpio_out         GPIO output register
//     irq              timer overflow interrupt (level)
module nibble_bus_responder #(
  parameter logic [3:0] BASE_PAGE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bus_addr,
  input  logic        bus_data_rw,
  input  logic [3:0]  bus_data_in,
  output logic [3:0]  bus_data_out,
  output logic        bus_data_oe,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out,
  output logic        irq
);

  logic [3:0] ram_q [32];
  logic [3:0] ram_d [32];
  logic       en_q, en_d, auto_q, auto_d, irq_en_q, irq_en_d;
  logic       ovf_q, ovf_d;
  logic [7:0] reload_q, reload_d;
  logic [7:0] count_q, count_d;
  logic [3:0] shadow_q, shadow_d;
  logic [7:0] gpio_out_q, gpio_out_d;
  logic [7:0] sync1_q, sync2_q;
  logic [3:0] rd_data_q, rd_data_d;
  logic       rd_oe_q, rd_oe_d;

  logic       sel, wr, rd, count_wr, tick;
  logic [7:0] off;
  logic [3:0] rd_nib;

  always_comb begin
    sel = (bus_addr[11:8] == BASE_PAGE);
    off = bus_addr[7:0];
    wr  = sel && bus_data_rw;
    rd  = sel && !bus_data_rw;

    ram_d      = ram_q;
    en_d       = en_q;
    auto_d     = auto_q;
    irq_en_d   = irq_en_q;
    ovf_d      = ovf_q;
    reload_d   = reload_q;
    count_d    = count_q;
    shadow_d   = shadow_q;
    gpio_out_d = gpio_out_q;

    count_wr = wr && ((off == 8'h24) || (off == 8'h25));

    // Bus writes first; timer effects below override where they collide.
    if (wr) begin
      if (off[7:5] == 3'b000) ram_d[off[4:0]] = bus_data_in;
      case (off)
        8'h20: begin
          en_d     = bus_data_in[0];
          auto_d   = bus_data_in[1];
          irq_en_d = bus_data_in[2];
        end
        8'h21: if (bus_data_in[0]) ovf_d = 1'b0;
        8'h22: reload_d[3:0]   = bus_data_in;
        8'h23: reload_d[7:4]   = bus_data_in;
        8'h24: count_d[3:0]    = bus_data_in;
        8'h25: count_d[7:4]    = bus_data_in;
        8'h30: gpio_out_d[3:0] = bus_data_in;
        8'h31: gpio_out_d[7:4] = bus_data_in;
        default: ;
      endcase
    end

    // A COUNT write suppresses the tick so the written nibble is kept as-is.
    tick = en_q && !count_wr;
    if (tick) begin
      if (count_q == 8'hFF) begin
        // Overflow set wins over a same-cycle W1C, and the one-shot stop
        // wins over a same-cycle CTRL write.
        ovf_d = 1'b1;
        if (auto_q) begin
          count_d = reload_q;
        end else begin
          count_d = 8'h00;
          en_d    = 1'b0;
        end
      end else begin
        count_d = count_q + 8'd1;
      end
    end

    case (off)
      8'h20:   rd_nib = {1'b0, irq_en_q, auto_q, en_q};
      8'h21:   rd_nib = {3'b000, ovf_q};
      8'h22:   rd_nib = reload_q[3:0];
      8'h23:   rd_nib = reload_q[7:4];
      8'h24:   rd_nib = count_q[3:0];
      8'h25:   rd_nib = shadow_q;
      8'h30:   rd_nib = gpio_out_q[3:0];
      8'h31:   rd_nib = gpio_out_q[7:4];
      8'h32:   rd_nib = sync2_q[3:0];
      8'h33:   rd_nib = sync2_q[7:4];
      default: rd_nib = (off[7:5] == 3'b000) ? ram_q[off[4:0]] : 4'h0;
    endcase

    // Reading the low count nibble freezes the high nibble for a coherent pair.
    if (rd && (off == 8'h24)) shadow_d = count_q[7:4];

    rd_data_d = rd ? rd_nib : 4'h0;
    rd_oe_d   = rd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_q      <= '{default: 4'h0};
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      reload_q   <= 8'h00;
      count_q    <= 8'h00;
      shadow_q   <= 4'h0;
      gpio_out_q <= 8'h00;
      sync1_q    <= 8'h00;
      sync2_q    <= 8'h00;
      rd_data_q  <= 4'h0;
      rd_oe_q    <= 1'b0;
    end else begin
      ram_q      <= ram_d;
      en_q       <= en_d;
      auto_q     <= auto_d;
      irq_en_q   <= irq_en_d;
      ovf_q      <= ovf_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      shadow_q   <= shadow_d;
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      rd_data_q  <= rd_data_d;
      rd_oe_q    <= rd_oe_d;
    end
  end

  assign bus_data_out = rd_data_q;
  assign bus_data_oe  = rd_oe_q;
  assign gpio_out     = gpio_out_q;
  assign irq          = ovf_q & irq_en_q;

endmodule

// File: tb/tb_nibble_bus_responder.sv
module tb_nibble_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] bus_addr = 12'h000;
  logic        bus_data_rw = 1'b0;
  logic [3:0]  bus_data_in = 4'h0;
  logic [3:0]  bus_data_out;
  logic        bus_data_oe;
  logic [7:0]  gpio_in = 8'h00;
  logic [7:0]  gpio_out;
  logic        irq;

  int total = 0;
  int bad   = 0;

  nibble_bus_responder #(.BASE_PAGE(4'hF)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_addr     (bus_addr),
    .bus_data_rw  (bus_data_rw),
    .bus_data_in  (bus_data_in),
    .bus_data_out (bus_data_out),
    .bus_data_oe  (bus_data_oe),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Each bus task spends exactly one rising edge; inputs change on falling edges.
  task automatic idle();
    bus_addr    = 12'h000;
    bus_data_rw = 1'b0;
    bus_data_in = 4'h0;
  endtask

  task automatic tick();
    idle();
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] page, input logic [7:0] off, input logic [3:0] d);
    bus_addr    = {page, off};
    bus_data_rw = 1'b1;
    bus_data_in = d;
    @(negedge clk);
    idle();
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] page, input logic [7:0] off,
                        input logic [3:0] exp_d, input logic exp_oe);
    bus_addr    = {page, off};
    bus_data_rw = 1'b0;
    @(negedge clk);
    chk(tag, {28'h0, bus_data_out}, {28'h0, exp_d});
    chk({tag, "_oe"}, {31'h0, bus_data_oe}, {31'h0, exp_oe});
    idle();
  endtask

  initial begin
    // Reset
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", {28'h0, bus_data_out}, 32'h0);
    chk("rst_oe", {31'h0, bus_data_oe}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_gpio", {24'h0, gpio_out}, 32'h0);
    rst_n = 1'b1;
    rd_chk("rd_ctrl", 4'hF, 8'h20, 4'h0, 1'b1);
    rd_chk("rd_stat", 4'hF, 8'h21, 4'h0, 1'b1);
    rd_chk("rd_cnt", 4'hF, 8'h24, 4'h0, 1'b1);
    rd_chk("rd_gpo", 4'hF, 8'h30, 4'h0, 1'b1);
    tick();
    chk("idle_oe", {31'h0, bus_data_oe}, 32'h0);

    // RAM and decode
    wr(4'hF, 8'h05, 4'hA);
    wr(4'hF, 8'h1F, 4'h3);
    rd_chk("ram05", 4'hF, 8'h05, 4'hA, 1'b1);
    rd_chk("ram1f", 4'hF, 8'h1F, 4'h3, 1'b1);
    rd_chk("off40", 4'hF, 8'h40, 4'h0, 1'b1);
    rd_chk("pageE", 4'hE, 8'h05, 4'h0, 1'b0);
    wr(4'hF, 8'h40, 4'h7);
    wr(4'hE, 8'h05, 4'h6);
    rd_chk("off40_w", 4'hF, 8'h40, 4'h0, 1'b1);
    rd_chk("ram05_2", 4'hF, 8'h05, 4'hA, 1'b1);

    // Auto-reload timer: COUNT=FD, RELOAD=10, CTRL=7 at edge E
    wr(4'hF, 8'h24, 4'hD);
    wr(4'hF, 8'h25, 4'hF);
    wr(4'hF, 8'h22, 4'h0);
    wr(4'hF, 8'h23, 4'h1);
    wr(4'hF, 8'h20, 4'h7);
    rd_chk("auto_lo", 4'hF, 8'h24, 4'hD, 1'b1);   // E+1 samples FD
    rd_chk("auto_hi", 4'hF, 8'h25, 4'hF, 1'b1);   // E+2, count now FF
    chk("auto_irq0", {31'h0, irq}, 32'h0);
    tick();                                         // E+3 overflow
    chk("auto_irq1", {31'h0, irq}, 32'h1);
    rd_chk("auto_ovf", 4'hF, 8'h21, 4'h1, 1'b1);  // E+4
    rd_chk("rel_lo", 4'hF, 8'h24, 4'h1, 1'b1);    // E+5 samples 11
    rd_chk("rel_hi", 4'hF, 8'h25, 4'h1, 1'b1);
    wr(4'hF, 8'h21, 4'h1);
    chk("w1c_irq", {31'h0, irq}, 32'h0);
    wr(4'hF, 8'h20, 4'h0);

    // One-shot: COUNT=FE, CTRL=5
    wr(4'hF, 8'h24, 4'hE);
    wr(4'hF, 8'h25, 4'hF);
    wr(4'hF, 8'h20, 4'h5);
    tick();
    tick();
    chk("os_irq", {31'h0, irq}, 32'h1);
    rd_chk("os_ctrl", 4'hF, 8'h20, 4'h4, 1'b1);
    rd_chk("os_lo", 4'hF, 8'h24, 4'h0, 1'b1);
    rd_chk("os_hi", 4'hF, 8'h25, 4'h0, 1'b1);
    tick();
    tick();
    rd_chk("os_hold", 4'hF, 8'h24, 4'h0, 1'b1);
    wr(4'hF, 8'h21, 4'h1);
    chk("os_clr", {31'h0, irq}, 32'h0);

    // Coherent read: count 0F, running
    wr(4'hF, 8'h24, 4'hF);
    wr(4'hF, 8'h25, 4'h0);
    wr(4'hF, 8'h20, 4'h1);
    rd_chk("coh_lo", 4'hF, 8'h24, 4'hF, 1'b1);
    rd_chk("coh_hi", 4'hF, 8'h25, 4'h0, 1'b1);
    rd_chk("coh_lo2", 4'hF, 8'h24, 4'h1, 1'b1);
    wr(4'hF, 8'h20, 4'h0);

    // GPIO synchronizer depth and output register
    gpio_in = 8'h5A;
    rd_chk("gpi_e1", 4'hF, 8'h32, 4'h0, 1'b1);
    rd_chk("gpi_e2", 4'hF, 8'h33, 4'h0, 1'b1);
    rd_chk("gpi_lo", 4'hF, 8'h32, 4'hA, 1'b1);
    rd_chk("gpi_hi", 4'hF, 8'h33, 4'h5, 1'b1);
    wr(4'hF, 8'h30, 4'hC);
    wr(4'hF, 8'h31, 4'h3);
    chk("gpo", {24'h0, gpio_out}, 32'h3C);
    rd_chk("gpo_lo", 4'hF, 8'h30, 4'hC, 1'b1);
    rd_chk("gpo_hi", 4'hF, 8'h31, 4'h3, 1'b1);

    // Collisions: W1C on the overflow edge, then COUNT write on a tick edge
    wr(4'hF, 8'h22, 4'h0);
    wr(4'hF, 8'h23, 4'h0);
    wr(4'hF, 8'h24, 4'hE);
    wr(4'hF, 8'h25, 4'hF);
    wr(4'hF, 8'h20, 4'h7);      // E
    tick();                      // E+1 -> FF
    wr(4'hF, 8'h21, 4'h1);      // E+2 overflow vs W1C
    chk("col_irq", {31'h0, irq}, 32'h1);
    rd_chk("col_ovf", 4'hF, 8'h21, 4'h1, 1'b1);  // E+3, count 00 -> 01
    wr(4'hF, 8'h24, 4'h5);      // E+4: count = 05, no increment
    rd_chk("col_cnt", 4'hF, 8'h24, 4'h5, 1'b1);
    wr(4'hF, 8'h20, 4'h0);
    wr(4'hF, 8'h21, 4'h1);

    // Reset during an access
    bus_addr    = 12'hF05;
    bus_data_rw = 1'b1;
    bus_data_in = 4'h9;
    rst_n       = 1'b0;
    @(negedge clk);
    bus_data_rw = 1'b0;
    @(negedge clk);
    chk("mid_oe", {31'h0, bus_data_oe}, 32'h0);
    chk("mid_out", {28'h0, bus_data_out}, 32'h0);
    rst_n = 1'b1;
    idle();
    rd_chk("mid_ram", 4'hF, 8'h05, 4'h0, 1'b1);
    chk("mid_gpo", {24'h0, gpio_out}, 32'h0);
    chk("mid_irq", {31'h0, irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_bus_responder.md
# nibble_bus_responder

Memory-mapped responder on the far end of the CPU's nibble bus (12-bit address, 4-bit data, read/write strobe). It decodes a 256-nibble page and serves a 32-nibble scratch RAM, an 8-bit timer with interrupt, and an 8-bit GPIO port. It sits beside the CPU in the top level, consuming the CPU's address, data and direction outputs and returning read data.

## Interface
- `BASE_PAGE`, default 4'hF: page matched against `bus_addr[11:8]`.
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `bus_addr` in 12: CPU address.
- `bus_data_rw` in 1: 1 = CPU write (CPU drives data), 0 = CPU read.
- `bus_data_in` in 4: write data from CPU.
- `bus_data_out` out 4: read data to CPU.
- `bus_data_oe` out 1: high when `bus_data_out` carries valid read data.
- `gpio_in` in 8: asynchronous external inputs.
- `gpio_out` out 8: GPIO output register.
- `irq` out 1: timer interrupt, level.

## Operation
- Select: `sel = (bus_addr[11:8] == BASE_PAGE)`; offset `off = bus_addr[7:0]`.
- Map (offsets hex):
  - 00–1F RAM[off], R/W.
  - 20 CTRL R/W: bit0 EN, bit1 AUTO, bit2 IRQ_EN, bit3 reads 0.
  - 21 STATUS: bit0 OVF; write 1 to bit0 clears, other bits read 0.
  - 22/23 RELOAD lo/hi nibble, R/W.
  - 24/25 COUNT lo/hi. Write loads that nibble. Read of 24 returns count[3:0] and latches count[7:4] into shadow. Read of 25 returns shadow.
  - 30/31 GPIO_OUT lo/hi, R/W.
  - 32/33 GPIO_IN lo/hi, read-only: two-flop-synchronized `gpio_in`.
  - All other offsets read 4'h0; writes ignored.
- Write: `sel && bus_data_rw` commits `bus_data_in` at the edge. Repeats every cycle the condition holds; writes are idempotent except STATUS W1C.
- Read: `sel && !bus_data_rw` registers the addressed nibble into `bus_data_out` and sets `bus_data_oe`. Otherwise next cycle `bus_data_out = 0` and `bus_data_oe = 0`.
- Timer tick: every cycle with EN=1, unless that cycle writes COUNT (24 or 25).
  - count < FF: count + 1.
  - count == FF: OVF <= 1. If AUTO=1, count <= RELOAD. If AUTO=0, count <= 00 and EN <= 0 (one-shot).
- `irq = OVF & IRQ_EN`, from registers, no combinational path from bus inputs.
- Priority:
  - COUNT write beats tick; no increment that cycle.
  - OVF set beats a same-cycle W1C clear.
  - CTRL write clearing EN in the same cycle as a one-shot overflow: OVF still sets.
- Arithmetic is 8-bit modulo; no other wrap paths.

## Timing
- Reset (`rst_n` = 0 at an edge): RAM all 0, CTRL = 0, OVF = 0, RELOAD = 00, COUNT = 00, shadow = 0, GPIO_OUT = 00, sync flops = 0, `bus_data_out` = 0, `bus_data_oe` = 0, `irq` = 0.
- Reset asserted mid-access aborts the access: the write is not committed, and the read output is 0 on the following cycle.
- Read latency 1 cycle: address presented in cycle N, data valid on `bus_data_out` during cycle N+1.
- Write latency: value visible to a read addressed in cycle N+1, with data in N+2.
- GPIO_IN latency: `gpio_in` change to readable value is 2 edges; add 1 cycle for read data.
- Timer: EN written 1 at edge E; first increment at edge E+1.
- `irq` rises the cycle after the edge that sets OVF.

## Test plan
- Reset, then read 20, 21, 24, 30 → `bus_data_out` = 0 with `bus_data_oe` = 1 one cycle later; `irq` = 0; `gpio_out` = 00.
- Write RAM[05] = A and RAM[1F] = 3; read back → A, 3. Read offset 40 → 0. Read page E (BASE_PAGE = F) → `bus_data_oe` = 0. Write to 40 → no state change.
- Write COUNT = FD (24 ← D, 25 ← F), RELOAD = 10, CTRL = 7 → count reaches FF, then OVF = 1, count = 10, `irq` = 1 the next cycle. Write 21 ← 1 → `irq` = 0.
- One-shot: COUNT = FE, CTRL = 5 → after 2 ticks count = 00, EN = 0, OVF = 1. Count then holds 00.
- Coherent read with count at 0F and running: read 24 → F. Read 25 on the next access → 0, even though count has become 10.
- `gpio_in` = 5A → after 2 cycles, read 32 → A and 33 → 5. Write 30 ← C, 31 ← 3 → `gpio_out` = 3C.
- Collisions: W1C clear of OVF on the overflow edge → OVF = 1. COUNT write on a tick edge → written value held, no increment.
